// File: rtl/midi_uart_rx_pkg.sv
// Shared definitions for the MIDI IN receive path: line rate, receiver
// FSM state encoding, MIDI status nibbles and the bit-vote helper.
`timescale 1ns/1ps
package midi_uart_rx_pkg;

  // Nominal MIDI line rate in bits per second
  localparam int MIDI_BAUD = 31250;

  // Status nibbles shared with the downstream message parser
  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  // Two-out-of-three majority used to decide each bit from three samples
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/midi_uart_rx_baud_tick.sv
// Oversampling tick generator for the MIDI receiver. Produces one tick
// every DIV enabled clocks; clr holds the divider at zero so the first
// tick after clr drops lands exactly DIV clocks later.
`timescale 1ns/1ps
module midi_baud_tick #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 31250,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic ce,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running 0..DIV-1 counter, frozen by ce and parked at 0 by clr
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (ce) begin
      if (clr || cnt == LAST) cnt <= '0;
      else                    cnt <= cnt + 1'b1;
    end
  end

  assign tick = ce && !clr && (cnt == LAST);

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI IN serial receiver (8N1, LSB first). Synchronizes the line,
// detects the start edge, majority-votes each bit around its centre and
// presents framed bytes on data/dv; bad stop bits raise frame_err once
// and the receiver then waits for the line to be released.
`timescale 1ns/1ps
module midi_uart_rx
  import midi_uart_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = MIDI_BAUD,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       rx,
  output logic [7:0] data,
  output logic       dv,
  output logic       frame_err,
  output logic       busy
);

  localparam int H  = OVERSAMPLE / 2;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_VOTE_A = TW'(H - 2);
  localparam logic [TW-1:0] T_VOTE_B = TW'(H - 1);
  localparam logic [TW-1:0] T_DECIDE = TW'(H);
  localparam logic [TW-1:0] T_LAST   = TW'(OVERSAMPLE - 1);

  logic          rx_meta;
  logic          rx_s;
  rx_state_t     state;
  logic [TW-1:0] tcnt;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          vote_a;
  logic          vote_b;
  logic          tick;
  logic          decide;
  logic          vote;

  // Tick divider is held in IDLE so sampling is phase-aligned to the start edge
  midi_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk (clk),
    .ce  (ce),
    .rst (rst),
    .clr (state == ST_IDLE),
    .tick(tick)
  );

  // Two-flop synchronizer for the asynchronous line, reset to idle-high
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else if (ce) begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Third vote sample is the live synchronized line at the decision tick
  assign decide = tick && (tcnt == T_DECIDE);
  assign vote   = majority3(vote_a, vote_b, rx_s);

  // Receiver FSM with bit sampling, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      tcnt      <= '0;
      bitcnt    <= 3'd0;
      shreg     <= 8'h00;
      vote_a    <= 1'b1;
      vote_b    <= 1'b1;
      data      <= 8'h00;
      dv        <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else if (ce) begin
      dv        <= 1'b0;
      frame_err <= 1'b0;
      if (tick) begin
        if (tcnt == T_VOTE_A) vote_a <= rx_s;
        if (tcnt == T_VOTE_B) vote_b <= rx_s;
        tcnt <= (tcnt == T_LAST) ? '0 : tcnt + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          tcnt <= '0;
          if (!rx_s) begin
            state <= ST_START;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (decide) begin
            if (!vote) begin
              state  <= ST_DATA;
              bitcnt <= 3'd0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (decide) begin
            shreg <= {vote, shreg[7:1]};
            if (bitcnt == 3'd7) state <= ST_STOP;
            else                bitcnt <= bitcnt + 3'd1;
          end
        end
        ST_STOP: begin
          if (decide) begin
            if (vote) begin
              data  <= shreg;
              dv    <= 1'b1;
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_midi_uart_rx.sv
// Testbench for midi_uart_rx: drives serial frames with real-valued bit
// timing and compares received bytes and strobes to the list of bytes sent.
`timescale 1ns/1ps
module tb_midi_uart_rx;

  localparam int  CLK_FREQ   = 4_000_000;
  localparam int  BAUD       = 31250;
  localparam int  OVERSAMPLE = 16;
  localparam int  DIV        = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam real CLK_NS     = 250.0;
  localparam real NOM_BIT_NS = 1.0e9 / BAUD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce  = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       dv;
  logic       frame_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] got_q[$];
  int         fe_seen      = 0;
  int         overlap_seen = 0;
  int         data_changes = 0;
  logic [7:0] held_data    = 8'h00;
  realtime    dv_time      = 0;
  logic [7:0] last_good    = 8'h00;

  // Clock generation
  always #(CLK_NS / 2.0) clk = ~clk;

  midi_uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .rx       (rx),
    .data     (data),
    .dv       (dv),
    .frame_err(frame_err),
    .busy     (busy)
  );

  // Collect strobes away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      held_data = 8'h00;
    end else begin
      if (dv) begin
        got_q.push_back(data);
        dv_time   = $realtime;
        held_data = data;
      end else if (data !== held_data) begin
        data_changes++;
        held_data = data;
      end
      if (frame_err) fe_seen++;
      if (dv && frame_err) overlap_seen++;
    end
  end

  // One 8N1 frame, LSB first, line left high afterwards
  task automatic send_byte(input logic [7:0] b, input real bit_ns, input logic stop_bit);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_bit;
    #(bit_ns);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (data !== 8'h00) begin failures++; $display("[TB] FAIL reset_data got=%h exp=00", data); end
    checks++; if (dv !== 1'b0) begin failures++; $display("[TB] FAIL reset_dv got=%b exp=0", dv); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_fe got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    int      fe0;
    logic    busy_mid;
    realtime t0;
    real     lat;
    got_q.delete();
    fe0 = fe_seen;
    @(negedge clk);
    t0 = $realtime;
    fork
      send_byte(8'h90, NOM_BIT_NS, 1'b1);
      begin #(4.5 * NOM_BIT_NS); busy_mid = busy; end
    join
    #(NOM_BIT_NS);
    @(negedge clk);
    last_good = 8'h90;
    lat = (dv_time - t0) / NOM_BIT_NS;
    checks++; if (got_q.size() != 1) begin failures++; $display("[TB] FAIL single_count got=%0d exp=1", got_q.size()); end
    checks++; if (got_q.size() > 0 && got_q[0] !== 8'h90) begin failures++; $display("[TB] FAIL single_data got=%h exp=90", got_q[0]); end
    checks++; if (fe_seen != fe0) begin failures++; $display("[TB] FAIL single_fe got=%0d exp=0", fe_seen - fe0); end
    checks++; if (busy_mid !== 1'b1) begin failures++; $display("[TB] FAIL single_busy_mid got=%b exp=1", busy_mid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_after got=%b exp=0", busy); end
    checks++; if (lat < 9.4 || lat > 9.8) begin failures++; $display("[TB] FAIL single_latency got=%f bits exp=9.4..9.8", lat); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    int         fe0;
    exp_q = '{8'h90, 8'h3C, 8'h64};
    got_q.delete();
    fe0 = fe_seen;
    @(negedge clk);
    foreach (exp_q[i]) send_byte(exp_q[i], NOM_BIT_NS, 1'b1);
    #(2 * NOM_BIT_NS);
    @(negedge clk);
    last_good = exp_q[exp_q.size() - 1];
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        failures++;
        $display("[TB] FAIL b2b_data[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (fe_seen != fe0) begin failures++; $display("[TB] FAIL b2b_fe got=%0d exp=0", fe_seen - fe0); end
  endtask

  task automatic test_glitch();
    int fe0;
    got_q.delete();
    fe0 = fe_seen;
    @(negedge clk);
    rx = 1'b0;
    #(3.0 * DIV * CLK_NS);
    rx = 1'b1;
    #(2 * NOM_BIT_NS);
    @(negedge clk);
    checks++; if (got_q.size() != 0) begin failures++; $display("[TB] FAIL glitch_dv got=%0d exp=0", got_q.size()); end
    checks++; if (fe_seen != fe0) begin failures++; $display("[TB] FAIL glitch_fe got=%0d exp=0", fe_seen - fe0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL glitch_busy got=%b exp=0", busy); end
  endtask

  task automatic test_break();
    int fe0;
    got_q.delete();
    fe0 = fe_seen;
    @(negedge clk);
    send_byte(8'h45, NOM_BIT_NS, 1'b0);
    rx = 1'b0;
    #(5 * NOM_BIT_NS);
    rx = 1'b1;
    #(2 * NOM_BIT_NS);
    @(negedge clk);
    checks++; if (fe_seen - fe0 != 1) begin failures++; $display("[TB] FAIL break_fe_count got=%0d exp=1", fe_seen - fe0); end
    checks++; if (got_q.size() != 0) begin failures++; $display("[TB] FAIL break_dv got=%0d exp=0", got_q.size()); end
    checks++; if (data !== last_good) begin failures++; $display("[TB] FAIL break_data_held got=%h exp=%h", data, last_good); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL break_busy got=%b exp=0", busy); end
    send_byte(8'h7F, NOM_BIT_NS, 1'b1);
    #(NOM_BIT_NS);
    @(negedge clk);
    last_good = 8'h7F;
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h7F) begin failures++; $display("[TB] FAIL break_recover got_n=%0d got=%h exp=7f", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    checks++; if (fe_seen - fe0 != 1) begin failures++; $display("[TB] FAIL break_fe_after got=%0d exp=1", fe_seen - fe0); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] b;
    int         fe0;
    b = 8'hA5;
    got_q.delete();
    fe0 = fe_seen;
    @(negedge clk);
    rx = 1'b0;
    #(NOM_BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      #(NOM_BIT_NS);
    end
    rx = b[4];
    #(NOM_BIT_NS / 2.0);
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (data !== 8'h00) begin failures++; $display("[TB] FAIL abort_data_reset got=%h exp=00", data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy got=%b exp=0", busy); end
    #(2 * NOM_BIT_NS);
    @(negedge clk);
    send_byte(8'h12, NOM_BIT_NS, 1'b1);
    #(NOM_BIT_NS);
    @(negedge clk);
    last_good = 8'h12;
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h12) begin failures++; $display("[TB] FAIL abort_next got_n=%0d got=%h exp=12", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    checks++; if (fe_seen != fe0) begin failures++; $display("[TB] FAIL abort_fe got=%0d exp=0", fe_seen - fe0); end
  endtask

  task automatic test_baud_tolerance();
    int         bauds[2];
    logic [7:0] exp_q[$];
    int         fe0;
    real        bit_ns;
    bauds = '{30300, 32200};
    exp_q = '{8'h00, 8'hFF, 8'h55};
    foreach (bauds[k]) begin
      got_q.delete();
      fe0    = fe_seen;
      bit_ns = 1.0e9 / bauds[k];
      @(negedge clk);
      foreach (exp_q[i]) send_byte(exp_q[i], bit_ns, 1'b1);
      #(2 * NOM_BIT_NS);
      @(negedge clk);
      last_good = exp_q[exp_q.size() - 1];
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL tol_count baud=%0d got=%0d exp=%0d", bauds[k], got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        checks++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
          failures++;
          $display("[TB] FAIL tol_data baud=%0d idx=%0d got=%h exp=%h", bauds[k], i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
        end
      end
      checks++; if (fe_seen != fe0) begin failures++; $display("[TB] FAIL tol_fe baud=%0d got=%0d exp=0", bauds[k], fe_seen - fe0); end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int         fe0;
    real        bit_ns;
    got_q.delete();
    fe0 = fe_seen;
    @(negedge clk);
    for (int n = 0; n < 10; n++) begin
      b      = 8'($urandom_range(0, 255));
      bit_ns = NOM_BIT_NS * (1.0 + (real'($urandom_range(0, 50)) - 25.0) / 1000.0);
      exp_q.push_back(b);
      send_byte(b, bit_ns, 1'b1);
      #(real'($urandom_range(0, 2)) * NOM_BIT_NS);
    end
    #(2 * NOM_BIT_NS);
    @(negedge clk);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        failures++;
        $display("[TB] FAIL rand_data[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (fe_seen != fe0) begin failures++; $display("[TB] FAIL rand_fe got=%0d exp=0", fe_seen - fe0); end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_abort();
    test_baud_tolerance();
    test_random();
    checks++; if (overlap_seen != 0) begin failures++; $display("[TB] FAIL strobe_overlap got=%0d exp=0", overlap_seen); end
    checks++; if (data_changes != 0) begin failures++; $display("[TB] FAIL data_stability got=%0d exp=0", data_changes); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
